my_dmux_8_way_sched: RTL
========================

Name: my_dmux_8_way_sched

Overview:
Sequencer that drives the shared my_dmux_8_way datapath.
- Directed mode: accepts one request (destination select plus data bit) through a valid/ready handshake and holds it on the demux for HOLD_CYCLES cycles.
- Sweep mode: walks a logic 1 across all eight outputs in order a..h.
- Provides registered, glitch-free drive of sel/in to the demux, plus busy and done status for the upstream controller.

Parameters:
- HOLD_CYCLES, 2, cycles each drive is held on the demux; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  directed request valid
- req_ready  output  1  scheduler can accept a directed request
- req_sel  input  3  destination select, 0=a .. 7=h
- req_in  input  1  data bit to route
- sweep_start  input  1  start an a..h sweep with in=1
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when an operation completes
- cur_sel  output  3  select currently driven to the demux
- a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out  output  1 each  demux outputs

Behaviour:
- Only one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, d_in=0, d_sel=0, cnt=0, done=0. Consequently all a..h outputs are 0, cur_sel=0 and busy=0.
- Demux inputs come straight from registers d_in/d_sel; a..h are combinational from those registers only.
- States: IDLE, HOLD, SWEEP.
- req_ready = (state==IDLE) && !sweep_start. It is combinational and is 0 during HOLD and SWEEP.
- IDLE:
  - sweep_start=1 takes priority: d_sel<=0, d_in<=1, cnt<=HOLD_CYCLES-1, go to SWEEP.
  - Otherwise, req_valid && req_ready: d_sel<=req_sel, d_in<=req_in, cnt<=HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - If cnt != 0: cnt decrements.
  - At cnt==0: d_in<=0, d_sel holds, done<=1, go to IDLE.
  - The driven value is visible for exactly HOLD_CYCLES cycles, starting the cycle after acceptance.
- SWEEP:
  - At cnt==0 with d_sel<7: d_sel increments and cnt reloads.
  - At cnt==0 with d_sel==7: d_in<=0, done<=1, go to IDLE.
  - Total high time is 8*HOLD_CYCLES cycles, with exactly one output high in each of those cycles.
- done is high for the single cycle after the last drive cycle (the first IDLE cycle). It is 0 otherwise.
- Throughput: at most one operation per HOLD_CYCLES+1 cycles, because of the mandatory IDLE cycle.
- sweep_start and req_valid arriving outside IDLE are ignored and not queued.
- req_in=0 still runs a full HOLD: all outputs stay 0 and done still pulses.
- Counter width is $clog2(HOLD_CYCLES+1). HOLD_CYCLES=1 gives single-cycle drives.
- Reset mid-operation: at the next edge the block is in IDLE with all outputs 0. No done pulse is produced for the aborted operation.

Optional Feature:
Macro: MY_DMUX_8_WAY_SCHED_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in HOLD or SWEEP sets d_in<=0 and returns to IDLE.
  - aborted pulses for one cycle; done stays 0.
  - abort is ignored in IDLE.
  - abort and reset together: reset wins, so aborted=0.
- Not defined: the abort and aborted ports are absent, and operations always run to completion.

Decomposition:
- Package my_dmux_sched_pkg:
  - localparam SEL_W=3
  - localparam N_OUT=8
  - typedef enum logic [1:0] {IDLE, HOLD, SWEEP} sched_state_t
- Sub-module: one instance of the existing my_dmux_8_way as the datapath.
- The FSM, counter and drive registers live in my_dmux_8_way_sched itself; no further sub-modules.

Test Plan:
All scenarios use HOLD_CYCLES=2.
1. Reset: hold reset for 2 cycles -> a..h=0, cur_sel=0, busy=0, done=0; req_ready=1 after release.
2. Directed request: req_sel=5, req_in=1, valid for one cycle, accepted at edge T -> f_out=1 and the others 0 in cycles T+1 and T+2; req_ready=0 in T+1 and T+2; done=1 only in T+3; all outputs 0 from T+3.
3. Zero data: req_sel=3, req_in=0 -> all outputs 0 throughout; busy=1 for 2 cycles; done still pulses after them.
4. Sweep: sweep_start pulse -> a_out high for 2 cycles, then b_out, and so on through h_out (16 cycles, always one-hot); req_valid=1 during the sweep is ignored (req_ready=0); done follows the last h_out cycle.
5. Collision: sweep_start=1 and req_valid=1 together in IDLE -> req_ready=0, the sweep starts, and the request is not accepted.
6. Reset mid-sweep while cur_sel=3 -> next cycle state is IDLE, a..h=0, cur_sel=0, done=0. With ABORT_EN, assert abort at the same point -> aborted=1 for 1 cycle, done=0.

Source files
------------

// File: rtl/my_dmux_sched_pkg.sv
// Shared widths and FSM state encoding for the my_dmux_8_way scheduler slice.
package my_dmux_sched_pkg;
  localparam int SEL_W = 3;
  localparam int N_OUT = 8;

  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} sched_state_t;
endpackage

// File: rtl/my_dmux_8_way.sv
// 1-to-8 demultiplexer: routes in to the output chosen by sel (0=a .. 7=h).
module my_dmux_8_way
  import my_dmux_sched_pkg::*;
(
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             h
);
  always_comb begin
    a = in && (sel == 3'd0);
    b = in && (sel == 3'd1);
    c = in && (sel == 3'd2);
    d = in && (sel == 3'd3);
    e = in && (sel == 3'd4);
    f = in && (sel == 3'd5);
    g = in && (sel == 3'd6);
    h = in && (sel == 3'd7);
  end
endmodule

// File: rtl/my_dmux_8_way_sched.sv
// Scheduler driving my_dmux_8_way with registered sel/in: directed holds and a..h sweeps.
// Optional abort input/aborted status enabled by defining MY_DMUX_8_WAY_SCHED_ABORT_EN.
module my_dmux_8_way_sched
  import my_dmux_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_in,
  input  logic             sweep_start,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] cur_sel,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             d_out,
  output logic             e_out,
  output logic             f_out,
  output logic             g_out,
  output logic             h_out
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_OUT - 1);

  sched_state_t     state, state_n;
  logic             d_in, d_in_n;
  logic [SEL_W-1:0] d_sel, d_sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done_n;
  logic             abort_req;
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
  logic             aborted_n;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign req_ready = (state == IDLE) && !sweep_start;
  assign busy      = (state != IDLE);
  assign cur_sel   = d_sel;

  always_comb begin
    state_n = state;
    d_in_n  = d_in;
    d_sel_n = d_sel;
    cnt_n   = cnt;
    done_n  = 1'b0;
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
    aborted_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sweep_start) begin
          d_sel_n = '0;
          d_in_n  = 1'b1;
          cnt_n   = RELOAD;
          state_n = SWEEP;
        end else if (req_valid) begin
          d_sel_n = req_sel;
          d_in_n  = req_in;
          cnt_n   = RELOAD;
          state_n = HOLD;
        end
      end
      HOLD, SWEEP: begin
        if (abort_req) begin
          // Abort ends the drive immediately; the normal done pulse is suppressed.
          d_in_n  = 1'b0;
          state_n = IDLE;
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
          aborted_n = 1'b1;
`endif
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (state == SWEEP && d_sel != LAST_SEL) begin
          d_sel_n = d_sel + 1'b1;
          cnt_n   = RELOAD;
        end else begin
          d_in_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      d_in  <= 1'b0;
      d_sel <= '0;
      cnt   <= '0;
      done  <= 1'b0;
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      state <= state_n;
      d_in  <= d_in_n;
      d_sel <= d_sel_n;
      cnt   <= cnt_n;
      done  <= done_n;
`ifdef MY_DMUX_8_WAY_SCHED_ABORT_EN
      aborted <= aborted_n;
`endif
    end
  end

  my_dmux_8_way u_dmux (
    .in  (d_in),
    .sel (d_sel),
    .a   (a_out),
    .b   (b_out),
    .c   (c_out),
    .d   (d_out),
    .e   (e_out),
    .f   (f_out),
    .g   (g_out),
    .h   (h_out)
  );
endmodule
